// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package rv32i_mem_arbiter_pkg;

   localparam int XLEN = 32;
   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_t;

   // One slot of the response pipe. 'store' remembers ls_we from the grant
   // cycle so the acknowledge can return 0 without re-sampling ls_we later.
   typedef struct packed {
      owner_t owner;
      logic   kill;
      logic   store;
   } pipe_entry_t;

   localparam pipe_entry_t ENTRY_IDLE = '{owner: OWN_NONE, kill: 1'b0, store: 1'b0};

   // Marks an in-flight fetch entry as discarded when a flush is seen.
   function automatic pipe_entry_t flush_entry(pipe_entry_t e, logic flush);
      pipe_entry_t r;
      r = e;
      if (flush && (e.owner == OWN_IF)) begin
         r.kill = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Core-side request/response and RAM-side signals of the memory arbiter.
// slave = arbiter view, master = core + RAM view.
interface rv32i_mem_arbiter_if
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int AW = XLEN,
   parameter int DW = XLEN
);
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_flush;
   logic            if_gnt;
   logic            if_rvalid;
   logic [DW-1:0]   if_rdata;

   logic            ls_req;
   logic            ls_we;
   logic [BE_W-1:0] ls_be;
   logic [AW-1:0]   ls_addr;
   logic [DW-1:0]   ls_wdata;
   logic            ls_gnt;
   logic            ls_rvalid;
   logic [DW-1:0]   ls_rdata;

   logic            mem_en;
   logic [BE_W-1:0] mem_we;
   logic [AW-3:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   logic            busy;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output if_req, if_addr, if_flush,
      output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy
   );

endinterface

// File: rtl/rv32i_mem_arbiter_resp_pipe.sv
// Owner/kill shift register: records who owns each RAM access in flight so
// the read data can be steered back MEM_LAT cycles after the grant.
module rv32i_mem_arbiter_resp_pipe
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  pipe_entry_t load,
   input  logic        flush,
   output pipe_entry_t exit_entry,
   output logic        busy
);

   pipe_entry_t stage [MEM_LAT];

   // Shift every cycle; a new grant enters unkilled, older fetch entries pick up a flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            stage[i] <= ENTRY_IDLE;
         end
      end else begin
         stage[0] <= load;
         for (int i = 1; i < MEM_LAT; i++) begin
            stage[i] <= flush_entry(stage[i-1], flush);
         end
      end
   end

   assign exit_entry = stage[MEM_LAT-1];

   // Killed entries still hold a slot, so they count as busy.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < MEM_LAT; i++) begin
         busy = busy | (stage[i].owner != OWN_NONE);
      end
   end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (IF) and
// load/store (LS) ports: one access per cycle, LS preferred unless IF has
// been held off for STARVE_MAX cycles, responses routed back by owner.
module rv32i_mem_arbiter
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int AW         = XLEN,
   parameter int DW         = XLEN,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   rv32i_mem_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   // starve_left counts down while IF is denied; IF takes priority at zero.
   logic [SW-1:0] starve_left;
   logic          if_prio;
   logic          if_gnt;
   logic          ls_gnt;
   pipe_entry_t   load_entry;
   pipe_entry_t   exit_entry;
   logic          pipe_busy;
   logic          if_rvalid;
   logic          ls_rvalid;
   logic          unused_addr_lsb;

   // Grants are gated by reset so nothing is issued while the pipe is held clear.
   always_comb begin
      if_prio = (starve_left == '0);
      if_gnt  = reset & bus.if_req & (~bus.ls_req | if_prio);
      ls_gnt  = reset & bus.ls_req & ~if_gnt;
   end

   // Drive the RAM with the granted request and build the pipe entry for it.
   always_comb begin
      bus.mem_en    = if_gnt | ls_gnt;
      bus.mem_we    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      load_entry    = ENTRY_IDLE;
      if (ls_gnt) begin
         bus.mem_we       = bus.ls_we ? bus.ls_be : '0;
         bus.mem_addr     = bus.ls_addr[AW-1:2];
         bus.mem_wdata    = bus.ls_wdata;
         load_entry.owner = OWN_LS;
         load_entry.store = bus.ls_we;
      end else if (if_gnt) begin
         bus.mem_addr     = bus.if_addr[AW-1:2];
         load_entry.owner = OWN_IF;
      end
   end

   // Starvation timer: reload when IF is idle or served, count down while denied.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_left <= SW'(STARVE_MAX);
      end else if (!bus.if_req || if_gnt) begin
         starve_left <= SW'(STARVE_MAX);
      end else if (!if_prio) begin
         starve_left <= starve_left - 1'b1;
      end
   end

   rv32i_mem_arbiter_resp_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_resp_pipe (
      .clk        (clk),
      .reset      (reset),
      .load       (load_entry),
      .flush      (bus.if_flush),
      .exit_entry (exit_entry),
      .busy       (pipe_busy)
   );

   // Steer the exiting RAM data to its owner. A flush in the exit cycle also
   // suppresses that fetch response, since it is still in flight.
   always_comb begin
      if_rvalid     = (exit_entry.owner == OWN_IF) & ~exit_entry.kill & ~bus.if_flush;
      ls_rvalid     = (exit_entry.owner == OWN_LS);
      bus.if_gnt    = if_gnt;
      bus.ls_gnt    = ls_gnt;
      bus.if_rvalid = if_rvalid;
      bus.ls_rvalid = ls_rvalid;
      bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
      bus.ls_rdata  = (ls_rvalid && !exit_entry.store) ? bus.mem_rdata : '0;
      bus.busy      = pipe_busy;
   end

   // RAM is word addressed; the byte-offset bits are intentionally dropped.
   assign unused_addr_lsb = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

endmodule
